// File: rtl/uart_fifo_tx_pkg.sv
// Shared UART definitions: FSM state encoding and bit-timing helpers.
// The matching receiver uses the same package.
package uart_fifo_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

    // Never returns 0 so that degenerate parameters still give legal vectors.
    function automatic int counter_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_fifo_tx_tick.sv
// Bit-period counter: tick is high on the final cycle of each bit period.
// While clear is high the counter holds at zero and tick stays low.
module baud_tick_gen
    import uart_fifo_tx_pkg::*;
#(
    parameter int SYMBOL_EDGE_TIME = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = counter_width(SYMBOL_EDGE_TIME);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);

    logic [CNT_W-1:0] count;

    assign tick = !clear && (count == LAST);

    // Restarting on tick makes every bit boundary begin from zero.
    always_ff @(posedge clk) begin
        if (rst || clear || tick)
            count <= '0;
        else
            count <= count + 1'b1;
    end

endmodule

// File: rtl/uart_fifo_tx.sv
// UART transmitter that pops words from a first-word fall-through FIFO
// and sends each one as start bit, LSB-first data bits and a stop bit.
module uart_fifo_tx
    import uart_fifo_tx_pkg::*;
#(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int WIDTH      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] fifo_dout,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    output logic             serial_out,
    output logic             busy
);

    localparam int SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int BIT_W = counter_width(WIDTH);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

    uart_state_t      state;
    uart_state_t      next_state;
    logic [BIT_W-1:0] bit_idx;
    logic [BIT_W-1:0] next_bit;
    logic [WIDTH-1:0] shift_reg;
    logic             load;
    logic             rd_en;
    logic             serial_d;
    logic             serial_q;
    logic             tick;
    logic             tick_clear;

    assign tick_clear = (state == IDLE);

    baud_tick_gen #(
        .SYMBOL_EDGE_TIME(SYMBOL_EDGE_TIME)
    ) u_baud_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clear(tick_clear),
        .tick (tick)
    );

    always_comb begin
        next_state = state;
        next_bit   = bit_idx;
        load       = 1'b0;
        rd_en      = 1'b0;
        serial_d   = 1'b1;

        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    rd_en      = 1'b1;
                    load       = 1'b1;
                    next_state = START;
                end
            end
            START: begin
                if (tick) begin
                    next_state = DATA;
                    next_bit   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx == LAST_BIT)
                        next_state = STOP;
                    else
                        next_bit = bit_idx + 1'b1;
                end
            end
            STOP: begin
                if (tick)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase

        // The line level is computed one cycle ahead so the output is a plain flop.
        case (next_state)
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_reg[next_bit];
            default: serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_idx   <= '0;
            shift_reg <= '0;
            serial_q  <= 1'b1;
        end else begin
            state    <= next_state;
            bit_idx  <= next_bit;
            serial_q <= serial_d;
            if (load)
                shift_reg <= fifo_dout;
        end
    end

    assign fifo_rd_en = rd_en && !rst;
    assign serial_out = serial_q;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Self-checking bench for uart_fifo_tx with a 10-cycle bit period.
// A small queue stands in for the FWFT FIFO and is popped on fifo_rd_en.
module tb_uart_fifo_tx;

    localparam int CLOCK_FREQ = 1000;
    localparam int BAUD_RATE  = 100;
    localparam int WIDTH      = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] fifo_dout = '0;
    logic             fifo_empty = 1'b1;
    logic             fifo_rd_en;
    logic             serial_out;
    logic             busy;

    always #5 clk = ~clk;

    uart_fifo_tx #(
        .CLOCK_FREQ(CLOCK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .WIDTH     (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_dout (fifo_dout),
        .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en),
        .serial_out(serial_out),
        .busy      (busy)
    );

    typedef struct {
        string      name;
        logic [7:0] data;
        logic [9:0] frame;
        bit         rand_inputs;
    } vec_t;

    logic [7:0] fifo_q[$];
    logic       rst_next  = 1'b1;
    logic       rand_mode = 1'b0;
    logic       serial_s  = 1'b1;
    logic       busy_s    = 1'b0;
    logic       rd_s      = 1'b0;
    logic       prev_rd_s = 1'b0;
    int         pop_count = 0;
    int         checks    = 0;
    int         passes    = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected)
            passes++;
        else
            $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, actual, expected);
    endtask

    task automatic applyStimulus();
        if (rand_mode) begin
            fifo_dout  = WIDTH'($urandom);
            fifo_empty = 1'($urandom_range(0, 1));
        end else begin
            fifo_empty = (fifo_q.size() == 0);
            fifo_dout  = fifo_empty ? '0 : fifo_q[0];
        end
    endtask

    // One clock: inputs move 1 time unit after the rising edge, outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (rd_s) begin
            pop_count++;
            if (fifo_q.size() > 0)
                fifo_q.delete(0);
        end
        rst = rst_next;
        applyStimulus();
        @(negedge clk);
        prev_rd_s = rd_s;
        serial_s  = serial_out;
        busy_s    = busy;
        rd_s      = fifo_rd_en;
    endtask

    task automatic captureFrame(input string name, input logic [9:0] frame,
                                input bit rand_inputs, output int gap);
        logic [9:0] sym [10];
        int         busy_cnt;
        int         rd_cnt;
        bit         found;
        busy_cnt = 0;
        rd_cnt   = 0;
        found    = 1'b0;
        gap      = 0;
        while (!found && gap < 50) begin
            step();
            if (serial_s == 1'b0)
                found = 1'b1;
            else
                gap++;
        end
        checkOutput($sformatf("%s start seen", name), int'(found), 1);
        if (!found)
            return;
        checkOutput($sformatf("%s pop one cycle before start", name), int'(prev_rd_s), 1);
        rand_mode = rand_inputs;
        for (int c = 0; c < 100; c++) begin
            if (c > 0)
                step();
            if (c == 80)
                rand_mode = 1'b0;
            sym[c / 10][c % 10] = serial_s;
            busy_cnt += int'(busy_s);
            rd_cnt   += int'(rd_s);
        end
        for (int s = 0; s < 10; s++)
            checkOutput($sformatf("%s symbol %0d", name, s), int'(sym[s]),
                        frame[s] ? 32'h3FF : 32'h000);
        checkOutput($sformatf("%s busy cycles", name), busy_cnt, 100);
        checkOutput($sformatf("%s pops inside frame", name), rd_cnt, 0);
        step();
        checkOutput($sformatf("%s idle cycle line", name), int'(serial_s), 1);
        checkOutput($sformatf("%s idle cycle busy", name), int'(busy_s), 0);
    endtask

    initial begin
        vec_t vecs[3];
        int   gap;
        int   base;
        int   low_cnt;
        int   rd_cnt;
        bit   found;

        // Frame patterns listed start bit first: {stop, data[7:0], start}.
        vecs[0] = '{name: "byte 0xA5", data: 8'hA5, frame: 10'h34A, rand_inputs: 1'b0};
        vecs[1] = '{name: "byte 0x01", data: 8'h01, frame: 10'h202, rand_inputs: 1'b0};
        vecs[2] = '{name: "byte 0x96 noisy inputs", data: 8'h96, frame: 10'h32C, rand_inputs: 1'b1};

        $display("[TB] reset with a non-empty FIFO");
        fifo_q.push_back(vecs[0].data);
        applyStimulus();
        for (int c = 0; c < 2; c++) begin
            step();
            checkOutput($sformatf("reset cycle %0d line", c), int'(serial_s), 1);
            checkOutput($sformatf("reset cycle %0d busy", c), int'(busy_s), 0);
            checkOutput($sformatf("reset cycle %0d rd_en", c), int'(rd_s), 0);
        end
        rst_next = 1'b0;

        $display("[TB] single frames");
        for (int i = 0; i < 3; i++) begin
            base = pop_count;
            if (i > 0)
                fifo_q.push_back(vecs[i].data);
            captureFrame(vecs[i].name, vecs[i].frame, vecs[i].rand_inputs, gap);
            checkOutput($sformatf("%s pop count", vecs[i].name), pop_count - base, 1);
        end

        $display("[TB] back-to-back frames");
        base = pop_count;
        fifo_q.push_back(8'h00);
        fifo_q.push_back(8'hFF);
        captureFrame("b2b 0x00", 10'h200, 1'b0, gap);
        captureFrame("b2b 0xFF", 10'h3FE, 1'b0, gap);
        checkOutput("b2b gap before second start", gap, 0);
        checkOutput("b2b pop count", pop_count - base, 2);

        $display("[TB] reset during data bit 3");
        base = pop_count;
        fifo_q.push_back(8'h3C);
        fifo_q.push_back(8'h81);
        found = 1'b0;
        for (int w = 0; w < 50 && !found; w++) begin
            step();
            found = (serial_s == 1'b0);
        end
        checkOutput("midreset start seen", int'(found), 1);
        for (int c = 1; c <= 44; c++)
            step();
        checkOutput("midreset data bit 3 of 0x3C", int'(serial_s), 1);
        rst_next = 1'b1;
        step();
        checkOutput("midreset rd_en during reset", int'(rd_s), 0);
        rst_next = 1'b0;
        step();
        checkOutput("midreset line after reset", int'(serial_s), 1);
        checkOutput("midreset busy after reset", int'(busy_s), 0);
        captureFrame("after reset 0x81", 10'h302, 1'b0, gap);
        checkOutput("after reset immediate start", gap, 0);
        checkOutput("midreset pop count", pop_count - base, 2);
        low_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            low_cnt += int'(!serial_s);
        end
        checkOutput("no resend of 0x3C", low_cnt, 0);

        $display("[TB] empty FIFO");
        base    = pop_count;
        low_cnt = 0;
        rd_cnt  = 0;
        for (int c = 0; c < 500; c++) begin
            step();
            low_cnt += int'(!serial_s);
            rd_cnt  += int'(rd_s);
        end
        checkOutput("empty rd_en cycles", rd_cnt, 0);
        checkOutput("empty line low cycles", low_cnt, 0);
        checkOutput("empty pop count", pop_count - base, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/uart_fifo_tx.md
UART_FIFO_TX -- requirements
Module: uart_fifo_tx

Interface
REQ-001 The block SHALL have parameter CLOCK_FREQ, default 125_000_000: the system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 115_200: the serial line rate in bits/s.
REQ-003 The block SHALL have parameter WIDTH, default 8: the data bits per frame.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 Port clk, input, 1: the system clock; all state updates on the rising edge.
REQ-006 Port rst, input, 1: the synchronous, active-high reset.
REQ-007 Port fifo_dout, input, WIDTH: the head word of the upstream FIFO, valid whenever fifo_empty=0 (first-word fall-through).
REQ-008 Port fifo_empty, input, 1: high when the upstream FIFO holds no words.
REQ-009 Port fifo_rd_en, output, 1: the pop strobe to the FIFO; each cycle it is high pops exactly one word.
REQ-010 Port serial_out, output, 1: the UART TX line; idle high.
REQ-011 Port busy, output, 1: high from the cycle after a pop until the last stop-bit cycle, inclusive.

Function
REQ-012 The block SHALL use SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE, computed by integer division; each bit lasts exactly SYMBOL_EDGE_TIME cycles.
REQ-013 The block SHALL implement states IDLE, START, DATA and STOP.
REQ-014 IDLE: fifo_rd_en SHALL equal (state==IDLE && !fifo_empty) combinationally, and in that cycle fifo_dout SHALL be captured into the shift register, with the transition to START.
REQ-015 IDLE with fifo_empty=1: the block SHALL stay in IDLE, with fifo_rd_en=0 and serial_out=1.
REQ-016 START: serial_out SHALL be 0 for SYMBOL_EDGE_TIME cycles, then the block SHALL go to DATA with bit index 0.
REQ-017 DATA: serial_out SHALL carry the data bits LSB first, each held SYMBOL_EDGE_TIME cycles; after bit WIDTH-1 the block SHALL go to STOP.
REQ-018 STOP: serial_out SHALL be 1 for SYMBOL_EDGE_TIME cycles, then the block SHALL go to IDLE.
REQ-019 Frame timing SHALL be a start edge one cycle after the pop cycle, and a frame of (WIDTH+2)*SYMBOL_EDGE_TIME cycles.
REQ-020 Back-to-back frames SHALL be separated by exactly one IDLE (high) cycle.
REQ-021 fifo_rd_en SHALL never be asserted outside IDLE, and never while fifo_empty=1; there SHALL be exactly one pop per frame.
REQ-022 Changes on fifo_dout or fifo_empty after the pop cycle SHALL NOT affect the frame in flight.
REQ-023 The symbol counter SHALL be $clog2(SYMBOL_EDGE_TIME) bits wide and reset to 0 on every bit boundary; the bit index SHALL be $clog2(WIDTH) bits wide, and neither SHALL wrap mid-bit.
REQ-024 serial_out SHALL be registered, with no combinational path from the inputs.

Reset
REQ-025 When rst=1 at a clock edge, the block SHALL enter IDLE next cycle, with serial_out=1, busy=0, fifo_rd_en=0 and counters at 0.
REQ-026 fifo_rd_en SHALL be forced to 0 during any cycle with rst=1.
REQ-027 On reset mid-frame, the frame SHALL be aborted, the line SHALL go high the next cycle, the popped word SHALL be discarded, and the block SHALL NOT re-pop it.
REQ-028 After reset release, the block SHALL start a new frame at the first IDLE cycle with fifo_empty=0.

Structure
REQ-029 A shared package SHALL hold the state encoding (2-bit IDLE=0, START=1, DATA=2, STOP=3) and the SYMBOL_EDGE_TIME/counter-width computation, shared with the matching receiver.
REQ-030 The block SHALL contain one sub-module, baud_tick_gen: a counter with clear input and tick output, asserting tick on the final cycle of each bit period.

Verification (CLOCK_FREQ=1000, BAUD_RATE=100, so SYMBOL_EDGE_TIME=10)
REQ-031 Reset scenario: rst=1 for 2 cycles with fifo_empty=0 -> serial_out=1, busy=0, fifo_rd_en=0 throughout.
REQ-032 Single-byte scenario: FIFO holds 0xA5 -> exactly one fifo_rd_en pulse, then serial_out = 0 x10, bits 1,0,1,0,0,1,0,1 x10 each, 1 x10; busy high for 100 cycles.
REQ-033 Empty scenario: fifo_empty=1 for 500 cycles -> fifo_rd_en never high, serial_out constant 1.
REQ-034 Back-to-back scenario: FIFO holds 0x00 then 0xFF -> two 100-cycle frames with exactly 1 high cycle between them, and exactly 2 pops.
REQ-035 Mid-frame reset scenario: rst pulsed during data bit 3 of 0x3C, with 0x81 queued -> line high next cycle; after release, the next frame carries 0x81 and 0x3C is not resent.
REQ-036 Input-change scenario: fifo_dout and fifo_empty toggled randomly mid-frame -> the frame in flight is bit-exact to the popped value.
